// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack controller: opcodes, FSM states,
// status codes, stack geometry and the acceptance-time depth check.
package rpn_pkg;
  localparam int STACK_DEPTH = 8;
  localparam int IDX_W       = 3;
  localparam int DEPTH_W     = 4;

  typedef enum logic [2:0] {
    OP_PUSH  = 3'b000,
    OP_POP   = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_SWAP  = 3'b101,
    OP_DUP   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR0  = 3'd3,
    ST_WR1  = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK  = 2'b00,
    ERR_OVF = 2'b01,
    ERR_UNF = 2'b10
  } err_e;

  // Decide at acceptance whether the command can run at the current depth.
  function automatic err_e check_depth(input op_e op, input logic [DEPTH_W-1:0] d);
    err_e e;
    e = ERR_OK;
    case (op)
      OP_PUSH: if (d == DEPTH_W'(STACK_DEPTH)) e = ERR_OVF;
      OP_POP:  if (d == '0) e = ERR_UNF;
      OP_DUP: begin
        if (d == '0) e = ERR_UNF;
        else if (d == DEPTH_W'(STACK_DEPTH)) e = ERR_OVF;
      end
      OP_ADD, OP_SUB, OP_AND, OP_SWAP: if (d < DEPTH_W'(2)) e = ERR_UNF;
      default: e = ERR_OK;
    endcase
    return e;
  endfunction
endpackage

// File: rtl/rpn_alu.sv
// Combinational binary operator for the stack: y = b op a, modulo 2^k.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int k = 16
) (
  input  logic [k-1:0] a,
  input  logic [k-1:0] b,
  input  op_e          op,
  output logic [k-1:0] y
);
  // b is the deeper operand, a the top of stack; carries/borrows drop off.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = b + a;
      OP_SUB:  y = b - a;
      OP_AND:  y = b & a;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN stack controller: sequences reads/writes on an external 8-entry
// register file and tracks the stack depth. No stack data is stored here,
// only the two operand latches A and B.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int k = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [k-1:0]     cmd_data,
  output logic             cmd_ready,
  output logic             done,
  output logic [1:0]       err,
  output logic [3:0]       depth,
  output logic             rf_write,
  output logic [2:0]       rf_wnum,
  output logic [k-1:0]     rf_wdata,
  output logic [2:0]       rf_rnum,
  input  logic [k-1:0]     rf_rdata
);
  state_e               r_state;
  op_e                  r_op;
  err_e                 r_err;
  logic [DEPTH_W-1:0]   r_depth, r_ndepth;
  logic [k-1:0]         r_a, r_b, r_wdata;
  logic                 r_done, r_write;
  logic [IDX_W-1:0]     r_wnum, r_rnum;

  op_e                  w_op;
  err_e                 w_chk;
  logic [IDX_W-1:0]     w_dm1, w_dm2;
  logic [k-1:0]         w_alu_y;

  assign w_op  = op_e'(cmd_op);
  assign w_chk = check_depth(w_op, r_depth);
  assign w_dm1 = r_depth[IDX_W-1:0] - IDX_W'(1);
  assign w_dm2 = r_depth[IDX_W-1:0] - IDX_W'(2);

  // B comes straight off the read port during RD_B so the result is
  // registered into the write data on the same edge that latches B.
  rpn_alu #(.k(k)) u_alu (
    .a  (r_a),
    .b  (rf_rdata),
    .op (r_op),
    .y  (w_alu_y)
  );

  // Reset is synchronous, so a write or done registered for this cycle is
  // masked while reset is high to abort cleanly mid-command.
  assign cmd_ready = (r_state == ST_IDLE);
  assign done      = r_done & ~reset;
  assign rf_write  = r_write & ~reset;
  assign err       = r_err;
  assign depth     = r_depth;
  assign rf_wnum   = r_wnum;
  assign rf_wdata  = r_wdata;
  assign rf_rnum   = r_rnum;

  // Command FSM; every output is registered for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_PUSH;
      r_err    <= ERR_OK;
      r_depth  <= '0;
      r_ndepth <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_wdata  <= '0;
      r_done   <= 1'b0;
      r_write  <= 1'b0;
      r_wnum   <= '0;
      r_rnum   <= '0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= ERR_OK;
      r_write <= 1'b0;
      r_wnum  <= '0;
      r_rnum  <= '0;
      case (r_state)
        ST_IDLE: if (cmd_valid) begin
          r_op <= w_op;
          if (w_chk != ERR_OK) begin
            r_state  <= ST_FIN;
            r_done   <= 1'b1;
            r_err    <= w_chk;
            r_ndepth <= r_depth;
          end else begin
            case (w_op)
              OP_PUSH: begin
                r_state  <= ST_WR0;
                r_write  <= 1'b1;
                r_wnum   <= r_depth[IDX_W-1:0];
                r_wdata  <= cmd_data;
                r_done   <= 1'b1;
                r_ndepth <= r_depth + DEPTH_W'(1);
              end
              OP_POP: begin
                r_state  <= ST_FIN;
                r_done   <= 1'b1;
                r_ndepth <= r_depth - DEPTH_W'(1);
              end
              OP_CLEAR: begin
                r_state  <= ST_FIN;
                r_done   <= 1'b1;
                r_ndepth <= '0;
              end
              OP_DUP: begin
                r_state  <= ST_RD_A;
                r_rnum   <= w_dm1;
                r_ndepth <= r_depth + DEPTH_W'(1);
              end
              default: begin
                r_state  <= ST_RD_A;
                r_rnum   <= w_dm1;
                r_ndepth <= (w_op == OP_SWAP) ? r_depth : r_depth - DEPTH_W'(1);
              end
            endcase
          end
        end
        ST_RD_A: begin
          r_a <= rf_rdata;
          if (r_op == OP_DUP) begin
            r_state <= ST_WR0;
            r_write <= 1'b1;
            r_wnum  <= r_depth[IDX_W-1:0];
            r_wdata <= rf_rdata;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RD_B;
            r_rnum  <= w_dm2;
          end
        end
        ST_RD_B: begin
          r_b     <= rf_rdata;
          r_state <= ST_WR0;
          r_write <= 1'b1;
          r_wnum  <= w_dm2;
          r_wdata <= (r_op == OP_SWAP) ? r_a : w_alu_y;
          r_done  <= (r_op != OP_SWAP);
        end
        ST_WR0: begin
          if (r_op == OP_SWAP) begin
            r_state <= ST_WR1;
            r_write <= 1'b1;
            r_wnum  <= w_dm1;
            r_wdata <= r_b;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_depth <= r_ndepth;
          end
        end
        ST_WR1, ST_FIN: begin
          r_state <= ST_IDLE;
          r_depth <= r_ndepth;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: directed scenarios plus random command streams,
// checked against a queue-based stack model and a behavioural register file.
module tb_rpn_stack_ctrl;
  localparam int K = 16;
  localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         AND_ = 3'd4, SWAP = 3'd5, DUP = 3'd6, CLEAR = 3'd7;

  logic          clk = 1'b0;
  logic          reset, cmd_valid;
  logic [2:0]    cmd_op;
  logic [K-1:0]  cmd_data;
  logic          cmd_ready, done, rf_write;
  logic [1:0]    err;
  logic [3:0]    depth;
  logic [2:0]    rf_wnum, rf_rnum;
  logic [K-1:0]  rf_wdata, rf_rdata;

  logic [K-1:0]  rf [8];
  logic [K-1:0]  stk [$];
  logic [18:0]   exp_w [$];
  logic [18:0]   obs_w [$];
  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  assign rf_rdata = rf[rf_rnum];
  always @(posedge clk) if (rf_write) rf[rf_wnum] <= rf_wdata;

  rpn_stack_ctrl #(.k(K)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .done(done), .err(err),
    .depth(depth), .rf_write(rf_write), .rf_wnum(rf_wnum),
    .rf_wdata(rf_wdata), .rf_rnum(rf_rnum), .rf_rdata(rf_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Stack semantics straight from the command definitions.
  task automatic model(input logic [2:0] op, input logic [K-1:0] d,
                       output logic [1:0] e, output int lat);
    int n;
    logic [K-1:0] a, b, r;
    n = stk.size();
    exp_w.delete();
    e = 2'b00;
    lat = 1;
    case (op)
      PUSH: if (n == 8) e = 2'b01;
            else begin exp_w.push_back({3'(n), d}); stk.push_back(d); end
      POP:  if (n == 0) e = 2'b10; else void'(stk.pop_back());
      ADD, SUB, AND_: if (n < 2) e = 2'b10;
            else begin
              a = stk[n-1]; b = stk[n-2];
              if (op == ADD) r = b + a; else if (op == SUB) r = b - a; else r = b & a;
              exp_w.push_back({3'(n-2), r});
              void'(stk.pop_back());
              stk[n-2] = r;
              lat = 3;
            end
      SWAP: if (n < 2) e = 2'b10;
            else begin
              a = stk[n-1]; b = stk[n-2];
              exp_w.push_back({3'(n-2), a});
              exp_w.push_back({3'(n-1), b});
              stk[n-2] = a; stk[n-1] = b;
              lat = 4;
            end
      DUP:  if (n == 0) e = 2'b10;
            else if (n == 8) e = 2'b01;
            else begin
              a = stk[n-1];
              exp_w.push_back({3'(n), a});
              stk.push_back(a);
              lat = 2;
            end
      default: stk.delete();
    endcase
  endtask

  // Issue one command (called at a negedge) and check the whole transaction.
  // hold keeps cmd_valid high with junk opcodes while the command is busy.
  task automatic issue(input logic [2:0] op, input logic [K-1:0] d, input bit hold);
    logic [1:0] e;
    int elat, lat, t, m;
    model(op, d, e, elat);
    obs_w.delete();
    t = 0;
    while (!cmd_ready && t < 10) begin @(negedge clk); t++; end
    check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = hold; cmd_op = 3'($urandom); cmd_data = K'($urandom);
    lat = 1;
    while (1) begin
      check("ready_while_busy", {31'd0, cmd_ready}, 32'd0);
      if (rf_write) obs_w.push_back({rf_wnum, rf_wdata});
      else check("wnum_idle_zero", {29'd0, rf_wnum}, 32'd0);
      if (done) break;
      if (lat >= 10) begin check("done_timeout", 32'(lat), 32'(elat)); break; end
      @(negedge clk);
      lat++;
      if (hold) begin cmd_op = 3'($urandom); cmd_data = K'($urandom); end
    end
    check("err", {30'd0, err}, {30'd0, e});
    check("latency", 32'(lat), 32'(elat));
    @(negedge clk);
    check("depth", {28'd0, depth}, 32'(stk.size()));
    check("done_single_pulse", {31'd0, done}, 32'd0);
    check("num_writes", 32'(obs_w.size()), 32'(exp_w.size()));
    m = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
    for (int i = 0; i < m; i++) check("write", {13'd0, obs_w[i]}, {13'd0, exp_w[i]});
    for (int i = 0; i < stk.size(); i++) check("rf_content", {16'd0, rf[i]}, {16'd0, stk[i]});
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_depth", {28'd0, depth}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {30'd0, err}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_write", {31'd0, rf_write}, 32'd0);
    check("rst_rnum", {29'd0, rf_rnum}, 32'd0);
    reset = 1'b0;
    stk.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    @(negedge clk);
    do_reset();

    // Basic push/push/sub.
    issue(PUSH, 16'h0005, 0);
    issue(PUSH, 16'h0003, 0);
    issue(SUB,  16'h0000, 0);
    check("sub_result_rf0", {16'd0, rf[0]}, 32'h0002);

    // Swap.
    do_reset();
    issue(PUSH, 16'h0001, 0);
    issue(PUSH, 16'h0002, 0);
    issue(SWAP, 16'h0000, 0);

    // Overflow, then clear and underflow.
    do_reset();
    for (int i = 0; i < 8; i++) issue(PUSH, 16'h0100 + 16'(i), 0);
    issue(PUSH, 16'h00FF, 0);
    issue(DUP,  16'h0000, 0);
    issue(CLEAR, 16'h0000, 0);
    issue(POP,  16'h0000, 0);
    issue(DUP,  16'h0000, 0);
    issue(ADD,  16'h0000, 0);
    issue(PUSH, 16'h0042, 0);
    issue(SWAP, 16'h0000, 0);

    // Wrap-around arithmetic.
    do_reset();
    issue(PUSH, 16'hFFFF, 0);
    issue(PUSH, 16'h0001, 0);
    issue(ADD,  16'h0000, 0);
    check("add_wrap", {16'd0, rf[0]}, 32'h0000);
    issue(PUSH, 16'h0001, 0);
    issue(SUB,  16'h0000, 0);
    check("sub_wrap", {16'd0, rf[0]}, 32'hFFFF);

    // Reset in the middle of an ADD (during RD_B).
    do_reset();
    issue(PUSH, 16'h0010, 0);
    issue(PUSH, 16'h0020, 0);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_data = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rd_a_rnum", {29'd0, rf_rnum}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_write", {31'd0, rf_write}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("abort_write2", {31'd0, rf_write}, 32'd0);
    check("abort_done2", {31'd0, done}, 32'd0);
    check("abort_depth", {28'd0, depth}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_depth2", {28'd0, depth}, 32'd0);
    check("abort_no_partial", {16'd0, rf[0]}, 32'h0010);
    stk.delete();

    // Busy-time commands are ignored.
    issue(PUSH, 16'h1111, 0);
    issue(PUSH, 16'h2222, 0);
    issue(SWAP, 16'h0000, 1);
    issue(PUSH, 16'h0077, 0);

    // Random streams; PUSH weighted to exercise deeper stacks.
    for (int i = 0; i < 250; i++) begin
      int r;
      logic [2:0] op;
      logic [K-1:0] d;
      r = $urandom_range(0, 11);
      op = (r >= 8) ? PUSH : 3'(r);
      d = ($urandom_range(0, 5) == 0) ? 16'hFFFF : K'($urandom);
      issue(op, d, $urandom_range(0, 3) == 0);
    end

    cmd_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/rpn_stack_ctrl.md
RPN_STACK_CTRL -- requirements
Module: rpn_stack_ctrl

Interface
REQ-001 SHALL have parameter: k, 16, data word width (matches register-file width).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: cmd_valid  input  1  command offered.
REQ-005 SHALL have port: cmd_op  input  3  opcode: 000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 AND, 101 SWAP, 110 DUP, 111 CLEAR.
REQ-006 SHALL have port: cmd_data  input  k  PUSH operand.
REQ-007 SHALL have port: cmd_ready  output  1  controller can accept a command.
REQ-008 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port: err  output  2  status, valid with done: 00 ok, 01 overflow, 10 underflow.
REQ-010 SHALL have port: depth  output  4  current stack depth, 0..8.
REQ-011 SHALL have port: rf_write, rf_wnum[2:0], rf_wdata[k-1:0]  output  register-file write strobe, index, data.
REQ-012 SHALL have port: rf_rnum  output  3  register-file read index.
REQ-013 SHALL have port: rf_rdata  input  k  combinational register-file read data for rf_rnum.

Function
REQ-014 SHALL accept a command on the posedge where cmd_valid and cmd_ready are both high; cmd_ready SHALL be high only in state IDLE.
REQ-015 SHALL latch cmd_op and cmd_data at acceptance; later input changes SHALL NOT affect the operation.
REQ-016 SHALL implement states IDLE, RD_A, RD_B, WR0, WR1, FIN; done SHALL be high exactly in the final non-IDLE cycle of each command; the next state is IDLE.
REQ-017 SHALL check depth at acceptance: PUSH or DUP with depth=8 gives err=01; POP or DUP with depth=0 gives err=10; ADD/SUB/AND/SWAP with depth<2 gives err=10; an error goes IDLE->FIN with no rf_write and no depth change.
REQ-018 PUSH SHALL go IDLE->WR0, writing rf[depth]=cmd_data, depth+1 (latency 1).
REQ-019 POP SHALL go IDLE->FIN, depth-1, with no register-file access; CLEAR SHALL go IDLE->FIN, depth=0.
REQ-020 ADD/SUB/AND SHALL go RD_A (rf_rnum=depth-1, latch A), RD_B (rf_rnum=depth-2, latch B), WR0 (rf[depth-2]=B op A, depth-1) (latency 3).
REQ-021 Arithmetic SHALL be k-bit modulo 2^k: ADD=B+A, SUB=B-A, AND=B&A; carry and borrow are discarded with no flag.
REQ-022 SWAP SHALL go RD_A, RD_B, WR0 (rf[depth-2]=A), WR1 (rf[depth-1]=B), with depth unchanged (latency 4).
REQ-023 DUP SHALL go RD_A, WR0 (rf[depth]=A), depth+1 (latency 2).
REQ-024 depth SHALL update only on the posedge ending the final state.
REQ-025 rf_write SHALL be high only in WR0/WR1 of a non-error command, for exactly one cycle per write.
REQ-026 rf_rnum and rf_wnum SHALL be 0 outside states that use them.
REQ-027 cmd_valid while busy SHALL be ignored; no command is queued.

Reset
REQ-028 SHALL, while reset is high at posedge clk, set state=IDLE, depth=0, done=0, err=00, A=B=0.
REQ-029 SHALL hold rf_write=0 during any cycle in which reset is high, aborting any command mid-operation with no partial write and no done.
REQ-030 SHALL NOT clear register-file contents; the stack is logically empty after reset.

Structure
REQ-031 Shared package rpn_pkg SHALL hold the opcode constants, state encoding, err codes, STACK_DEPTH=8 and index width 3.
REQ-032 Combinational ADD/SUB/AND SHALL be one sub-module rpn_alu (inputs a, b, op; output y), parameterised by k.
REQ-033 The controller SHALL drive the existing register file (3-bit indices decoded to one-hot externally); it SHALL NOT contain storage for stack data.

Verification
REQ-034 Reset, PUSH 0x0005, PUSH 0x0003, SUB -> writes rf[0]=0x0005, rf[1]=0x0003, then rf[0]=0x0002; depth 1; SUB done 3 cycles after acceptance; err=00.
REQ-035 PUSH 0x0001, PUSH 0x0002, SWAP -> rf[0]=0x0002, rf[1]=0x0001; done at 4th cycle; depth 2.
REQ-036 8x PUSH then PUSH 0x00FF -> err=01, no rf_write, depth stays 8; then POP at depth 0 after CLEAR -> err=10, depth 0.
REQ-037 PUSH 0xFFFF, PUSH 0x0001, ADD -> result 0x0000 (wrap); SUB of 0x0000-0x0001 -> 0xFFFF.
REQ-038 Assert reset during RD_B of an ADD -> no rf_write, no done, depth=0, cmd_ready=1 the cycle after reset deasserts.
REQ-039 cmd_valid held high with changing cmd_op during a SWAP -> only the first command executes; the next is accepted in IDLE.
